// File: rtl/uart_top.sv
// uart_top: 8N1 UART loopback/transmit block.
// Bytes arrive either from the serial rx line or from host writes (test_Data on
// a wr_Sig rising edge). Both sources share one FIFO, which the transmitter
// drains onto tx while the active-low button_Trig is held.

module uart_top #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DIV        = (CLK_FREQ + BAUD / 2) / BAUD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [7:0] test_Data,
  input  logic       wr_Sig,
  input  logic       button_Trig,
  output logic       tx
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Counter values at which a full bit period or half a bit period has elapsed.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;
  logic bt_meta, bt_sync;

  // Two-flop synchronisers for the asynchronous inputs, plus one extra stage on
  // rx so a falling edge can be seen. Idle level of both lines is high.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like real hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      bt_meta <= 1'b1;
      bt_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      bt_meta <= button_Trig;
      bt_sync <= bt_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  uart_state_t      rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_fall, rx_half_tick, rx_bit_tick;
  logic             rx_cnt_clr, rx_sample, rx_push;

  assign rx_fall      = rx_prev & ~rx_sync;
  assign rx_half_tick = (rx_cnt == HALF_LAST);
  assign rx_bit_tick  = (rx_cnt == BIT_LAST);

  // RX state register.
  always_ff @(posedge clk) begin
    if (reset) rx_state <= IDLE;
    else       rx_state <= rx_next;
  end

  // RX next state: hunt for a start edge, confirm it at mid-bit, collect eight
  // bits at their centres, then judge the stop bit.
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (rx_fall) rx_next = START;
      START:   if (rx_half_tick) rx_next = rx_sync ? IDLE : DATA;
      DATA:    if (rx_bit_tick && (rx_bit == 3'd7)) rx_next = STOP;
      STOP:    if (rx_bit_tick) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  // RX outputs: counter restart points, data-bit sample strobe, byte push.
  always_comb begin
    rx_cnt_clr = 1'b1;
    rx_sample  = 1'b0;
    rx_push    = 1'b0;
    case (rx_state)
      IDLE:  rx_cnt_clr = 1'b1;
      START: rx_cnt_clr = rx_half_tick;
      DATA: begin
        rx_cnt_clr = rx_bit_tick;
        rx_sample  = rx_bit_tick;
      end
      STOP: begin
        rx_cnt_clr = rx_bit_tick;
        rx_push    = rx_bit_tick & rx_sync;
      end
      default: rx_cnt_clr = 1'b1;
    endcase
  end

  // RX datapath: baud counter, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_cnt <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
      if (rx_state == IDLE) rx_bit <= '0;
      if (rx_sample) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO write arbitration (host writes win, RX byte parks for one cycle)
  // ---------------------------------------------------------------------------
  logic       wr_prev, wr_edge;
  logic       hold_valid, hold_load, hold_clear;
  logic [7:0] hold_data;
  logic       fifo_we;
  logic [7:0] fifo_wdata;

  assign wr_edge = wr_Sig & ~wr_prev;

  // Edge detector for the host write strobe; a held-high wr_Sig writes once.
  always_ff @(posedge clk) begin
    if (reset) wr_prev <= 1'b0;
    else       wr_prev <= wr_Sig;
  end

  // Single write port: host edge first, then a parked RX byte, then a fresh one.
  always_comb begin
    fifo_we    = 1'b0;
    fifo_wdata = test_Data;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (wr_edge) begin
      fifo_we    = 1'b1;
      fifo_wdata = test_Data;
      hold_load  = rx_push;
    end else if (hold_valid) begin
      fifo_we    = 1'b1;
      fifo_wdata = hold_data;
      hold_clear = 1'b1;
      hold_load  = rx_push;
    end else if (rx_push) begin
      fifo_we    = 1'b1;
      fifo_wdata = rx_shift;
    end
  end

  // One-entry holding register for an RX byte that lost arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      hold_data  <= rx_shift;
    end else if (hold_clear) begin
      hold_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [7:0]     fifo_rdata;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_rdata = fifo_mem[rd_ptr[PTR_W-1:0]];

  // FIFO storage; writes while full are dropped.
  // NOTE: the storage array has no reset; the pointers alone define what is
  // valid, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fifo_we && !fifo_full) fifo_mem[wr_ptr[PTR_W-1:0]] <= fifo_wdata;
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_we && !fifo_full) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)              rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  uart_state_t      tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_bit_tick, tx_go, tx_shift_en;

  assign tx_bit_tick = (tx_cnt == BIT_LAST);
  assign tx_go       = ~bt_sync & ~fifo_empty;

  // TX state register.
  always_ff @(posedge clk) begin
    if (reset) tx_state <= IDLE;
    else       tx_state <= tx_next;
  end

  // TX next state: the enable is only looked at in IDLE, so a frame in flight
  // always completes.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (tx_go) tx_next = START;
      START:   if (tx_bit_tick) tx_next = DATA;
      DATA:    if (tx_bit_tick && (tx_bit == 3'd7)) tx_next = STOP;
      STOP:    if (tx_bit_tick) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
  end

  // TX outputs: pop strobe, shift strobe and the serial line itself.
  always_comb begin
    fifo_pop    = 1'b0;
    tx_shift_en = 1'b0;
    tx          = 1'b1;
    case (tx_state)
      IDLE:  fifo_pop = tx_go;
      START: tx = 1'b0;
      DATA: begin
        tx          = tx_shift[0];
        tx_shift_en = tx_bit_tick;
      end
      STOP:    tx = 1'b1;
      default: tx = 1'b1;
    endcase
  end

  // TX datapath: baud counter restarts in IDLE and at each bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_cnt <= ((tx_state == IDLE) || tx_bit_tick) ? '0 : tx_cnt + 1'b1;
      if (tx_state == IDLE) tx_bit <= '0;
      if (fifo_pop) tx_shift <= fifo_rdata;
      if (tx_shift_en) begin
        tx_shift <= {1'b1, tx_shift[7:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top with a shortened bit period.
// A line monitor decodes every tx frame into got_q; the reference model is a
// byte queue (exp_q) bounded by the FIFO depth.

module tb_uart_top;

  localparam int DIV   = 16;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] test_Data = 8'h00;
  logic       wr_Sig = 1'b0;
  logic       button_Trig = 1'b1;
  logic       tx;

  uart_top #(
    .CLK_FREQ  (DIV * 9600),
    .BAUD      (9600),
    .DIV       (DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .test_Data  (test_Data),
    .wr_Sig     (wr_Sig),
    .button_Trig(button_Trig),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          frame_err = 0;
  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  logic        tx_last = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic mon_wait(input int n, inout bit aborted);
    repeat (n) begin
      @(negedge clk);
      if (reset) aborted = 1'b1;
    end
  endtask

  initial begin : line_monitor
    bit         aborted;
    logic [7:0] b;
    logic       start_v, stop_v;
    forever begin
      @(negedge clk);
      if (!reset && tx_last === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        mon_wait(DIV / 2, aborted);
        start_v = tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(DIV, aborted);
          b[i] = tx;
        end
        mon_wait(DIV, aborted);
        stop_v = tx;
        if (!aborted) begin
          got_q.push_back(b);
          if (start_v !== 1'b0 || stop_v !== 1'b1) frame_err++;
        end
      end
      tx_last = tx;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic rx_level(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_v);
    rx_level(1'b0);
    for (int i = 0; i < 8; i++) rx_level(b[i]);
    rx_level(stop_v);
    rx = 1'b1;
  endtask

  task automatic host_write(input logic [7:0] b, input int hold);
    test_Data = b;
    wr_Sig = 1'b1;
    repeat (hold) @(negedge clk);
    wr_Sig = 1'b0;
    @(negedge clk);
  endtask

  // Reference model: a write lands only if fewer than DEPTH bytes are pending.
  task automatic model_write(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (DIV) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_framing"}, frame_err, 0);
    got_q.delete();
    exp_q.delete();
    frame_err = 0;
  endtask

  task automatic tx_quiet(input int n, input string tag);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    logic [9:0] f93;
    int         errs, c, n, trans;
    logic [7:0] b;
    bit         ok, cur_a, prev_a, first_a;

    // Reset state
    repeat (5) @(negedge clk);
    reset = 1'b0;
    check("reset_tx_high", tx, 1'b1);
    tx_quiet(3 * DIV, "reset_idle_tx");
    check("reset_no_frames", got_q.size(), 0);

    // Single host byte 0x93 with exact per-clock line shape
    button_Trig = 1'b0;
    repeat (4) @(negedge clk);
    model_write(8'h93);
    host_write(8'h93, 1);
    c = 0;
    while (tx !== 1'b0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("t93_start_seen", tx, 1'b0);
    f93 = {1'b1, 8'h93, 1'b0};
    errs = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (tx !== f93[k / DIV]) errs++;
      @(negedge clk);
    end
    check("t93_bit_timing", errs, 0);
    tx_quiet(3 * DIV, "t93_idle_after");
    wait_frames(1, FRAME);
    compare("t93");

    // Random host writes with the transmitter held off (may overflow)
    for (int r = 0; r < 2; r++) begin
      button_Trig = 1'b1;
      repeat (4) @(negedge clk);
      n = $urandom_range(8, 20);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        model_write(b);
        host_write(b, $urandom_range(1, 3));
      end
      button_Trig = 1'b0;
      wait_frames(exp_q.size(), (exp_q.size() + 1) * (FRAME + 4));
      compare($sformatf("rand_host%0d", r));
    end

    // RX loopback: 0x11..0x88 then random bytes, random idle gaps
    button_Trig = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b = (i < 8) ? 8'((i + 1) * 8'h11) : 8'($urandom);
      model_write(b);
      send_rx(b, 1'b1);
      repeat ($urandom_range(0, 3 * DIV)) @(negedge clk);
    end
    wait_frames(exp_q.size(), 4 * (FRAME + 4));
    compare("loopback");

    // Framing error and short glitch: nothing must be pushed
    send_rx(8'h55, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx = 1'b1;
    tx_quiet(2 * FRAME, "err_tx_idle");
    check("err_no_frames", got_q.size(), 0);
    b = 8'($urandom);
    model_write(b);
    send_rx(b, 1'b1);
    wait_frames(1, 2 * FRAME);
    compare("err_recover");

    // Overflow: 17 writes 0x00..0x10, only the first 16 survive
    button_Trig = 1'b1;
    repeat (4) @(negedge clk);
    for (int v = 0; v <= 16; v++) begin
      model_write(8'(v));
      host_write(8'(v), 1);
    end
    check("ovf_model_depth", exp_q.size(), DEPTH);
    button_Trig = 1'b0;
    wait_frames(DEPTH, (DEPTH + 2) * (FRAME + 4));
    compare("overflow");

    // Host write 0xA5 swept across the stop bit of an RX 0x3C frame
    button_Trig = 1'b1;
    repeat (4) @(negedge clk);
    trans = 0;
    prev_a = 1'b0;
    first_a = 1'b0;
    for (int k = 0; k < DIV; k++) begin
      fork
        send_rx(8'h3C, 1'b1);
        begin
          repeat (9 * DIV + k) @(negedge clk);
          host_write(8'hA5, 1);
        end
      join
      button_Trig = 1'b0;
      wait_frames(2, 3 * (FRAME + 4));
      button_Trig = 1'b1;
      check($sformatf("coll%0d_count", k), got_q.size(), 2);
      ok = (got_q.size() == 2) &&
           ((got_q[0] == 8'hA5 && got_q[1] == 8'h3C) ||
            (got_q[0] == 8'h3C && got_q[1] == 8'hA5));
      check($sformatf("coll%0d_pair", k), ok, 1'b1);
      cur_a = (got_q.size() > 0) && (got_q[0] == 8'hA5);
      if (k == 0) first_a = cur_a;
      else if (cur_a != prev_a) trans++;
      prev_a = cur_a;
      got_q.delete();
      repeat (DIV) @(negedge clk);
    end
    check("coll_early_wr_first", first_a, 1'b1);
    check("coll_late_rx_first", prev_a, 1'b0);
    check("coll_single_order_flip", trans, 1);
    check("coll_framing", frame_err, 0);
    frame_err = 0;

    // Reset in the middle of a transmitted frame
    button_Trig = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) host_write(8'($urandom), 1);
    c = 0;
    while (tx !== 1'b0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    repeat (3 * DIV) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_high", tx, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    tx_quiet(4 * FRAME, "rst_no_more_frames");
    check("rst_fifo_empty", got_q.size(), 0);
    b = 8'($urandom);
    model_write(b);
    host_write(b, 1);
    wait_frames(1, 2 * FRAME);
    tx_quiet(2 * FRAME, "rst_single_frame_only");
    compare("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
